// File: rtl/dsp_pkg.sv
// dsp_pkg: shared constants and FSM state type for the DSP MAC sequencer.
// Opmode encodings target a DSP48A1 slice with CARRYINSEL=OPMODE5.
package dsp_pkg;

  localparam int DATA_W_DEF = 18;
  localparam int ACC_W_DEF  = 48;

  localparam logic [7:0] OPM_FIRST = 8'h01;
  localparam logic [7:0] OPM_ACC   = 8'h09;
  localparam logic [7:0] OPM_HOLD  = 8'h08;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

endpackage

// File: rtl/dsp_mac_sequencer_if.sv
// dsp_mac_sequencer_if: operand input stream and result output stream.
// slave is the sequencer's view, master the producer/consumer side.
interface dsp_mac_sequencer_if
  import dsp_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int OUT_W  = 32
);

  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_a;
  logic [DATA_W-1:0] s_b;
  logic              m_valid;
  logic              m_ready;
  logic [OUT_W-1:0]  m_data;
  logic              m_carry;
  logic              m_sat;

  modport slave (
    input  s_valid, s_a, s_b, m_ready,
    output s_ready, m_valid, m_data, m_carry, m_sat
  );

  modport master (
    output s_valid, s_a, s_b, m_ready,
    input  s_ready, m_valid, m_data, m_carry, m_sat
  );

endinterface

// File: rtl/dsp_opm_delay.sv
// dsp_opm_delay: W-bit x DEPTH-deep register delay line for opmode tags.
// Every stage resets asynchronously to zero.
module dsp_opm_delay #(
  parameter int W     = 8,
  parameter int DEPTH = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] pipe [DEPTH];

  // shift the tag one stage per cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++)
        pipe[i] <= '0;
    end else begin
      pipe[0] <= d;
      for (int i = 1; i < DEPTH; i++)
        pipe[i] <= pipe[i-1];
    end
  end

  assign q = pipe[DEPTH-1];

endmodule

// File: rtl/dsp_mac_sequencer.sv
// dsp_mac_sequencer: drives a DSP48A1 slice through a cfg_len-product MAC
// and returns P/CARRYOUT as one result word. Optional macro: MAC_SAT_EN.
module dsp_mac_sequencer
  import dsp_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ACC_W    = ACC_W_DEF,
  parameter int LEN_W    = 8,
  parameter int OUT_W    = 32,
  parameter int PIPE_LAT = 3,
  parameter int OPM_SKEW = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LEN_W-1:0]  cfg_len,
  output logic              busy,
  dsp_mac_sequencer_if.slave io,
  output logic [DATA_W-1:0] dsp_a,
  output logic [DATA_W-1:0] dsp_b,
  output logic [7:0]        dsp_opmode,
  input  logic [ACC_W-1:0]  dsp_p,
  input  logic              dsp_carryout
);

  localparam int CNT_W = $clog2(PIPE_LAT + 1);

  state_t             state, state_n;
  logic [LEN_W-1:0]   remaining;
  logic               first;
  logic [CNT_W-1:0]   cnt;
  logic               accept, load, capture, zero_job;
  logic [7:0]         tag;
  logic [OUT_W-1:0]   res;
  logic               sat;
  logic [OUT_W-1:0]   m_data_q;
  logic               m_carry_q, m_sat_q;

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // next state, beat acceptance and opmode tag
  always_comb begin
    state_n  = state;
    tag      = OPM_HOLD;
    accept   = 1'b0;
    load     = 1'b0;
    capture  = 1'b0;
    zero_job = 1'b0;
    unique case (state)
      IDLE: begin
        if (start && cfg_len != '0) begin
          load    = 1'b1;
          state_n = RUN;
        end else if (start) begin
          zero_job = 1'b1;
          state_n  = DONE;
        end
      end
      RUN: begin
        if (io.s_valid) begin
          accept = 1'b1;
          tag    = first ? OPM_FIRST : OPM_ACC;
          if (remaining == LEN_W'(1))
            state_n = DRAIN;
        end
      end
      DRAIN: begin
        if (cnt == CNT_W'(PIPE_LAT)) begin
          capture = 1'b1;
          state_n = DONE;
        end
      end
      DONE: begin
        if (io.m_ready)
          state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // beat bookkeeping and drain wait counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      remaining <= '0;
      first     <= 1'b0;
      cnt       <= '0;
    end else begin
      if (load) begin
        remaining <= cfg_len;
        first     <= 1'b1;
      end else if (accept) begin
        remaining <= remaining - 1'b1;
        first     <= 1'b0;
      end
      if (state == DRAIN) cnt <= cnt + 1'b1;
      else                cnt <= '0;
    end
  end

  // operand registers hold through bubbles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dsp_a <= '0;
      dsp_b <= '0;
    end else if (accept) begin
      dsp_a <= io.s_a;
      dsp_b <= io.s_b;
    end
  end

  // tag lags the operand register by OPM_SKEW cycles
  dsp_opm_delay #(
    .W     (8),
    .DEPTH (OPM_SKEW + 1)
  ) u_opm_delay (
    .clk (clk),
    .rst (rst),
    .d   (tag),
    .q   (dsp_opmode)
  );

`ifdef MAC_SAT_EN
  // clamp when P does not fit in OUT_W bits or the accumulator wrapped
  always_comb begin
    sat = (|dsp_p[ACC_W-1:OUT_W]) | dsp_carryout;
    res = sat ? '1 : dsp_p[OUT_W-1:0];
  end
`else
  logic unused_p_hi;
  assign unused_p_hi = ^dsp_p[ACC_W-1:OUT_W];

  // plain truncation of P
  always_comb begin
    sat = 1'b0;
    res = dsp_p[OUT_W-1:0];
  end
`endif

  // result capture, held until the handshake
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_data_q  <= '0;
      m_carry_q <= 1'b0;
      m_sat_q   <= 1'b0;
    end else if (zero_job) begin
      m_data_q  <= '0;
      m_carry_q <= 1'b0;
      m_sat_q   <= 1'b0;
    end else if (capture) begin
      m_data_q  <= res;
      m_carry_q <= dsp_carryout;
      m_sat_q   <= sat;
    end
  end

  assign busy       = (state != IDLE);
  assign io.s_ready = (state == RUN);
  assign io.m_valid = (state == DONE);
  assign io.m_data  = m_data_q;
  assign io.m_carry = m_carry_q;
  assign io.m_sat   = m_sat_q;

endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// tb_dsp_mac_sequencer: sequencer driving a behavioural DSP48A1 slice.
// Table vectors, corner sequences and random jobs vs a sum-of-products model.
module tb_dsp_mac_sequencer;
  import dsp_pkg::*;

  logic        clk, rst, start, busy;
  logic [7:0]  cfg_len;
  logic [17:0] dsp_a, dsp_b;
  logic [7:0]  dsp_opmode;
  logic [47:0] dsp_p;
  logic        dsp_carryout;

  dsp_mac_sequencer_if #(.DATA_W(18), .OUT_W(32)) io ();

  dsp_mac_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .cfg_len      (cfg_len),
    .busy         (busy),
    .io           (io),
    .dsp_a        (dsp_a),
    .dsp_b        (dsp_b),
    .dsp_opmode   (dsp_opmode),
    .dsp_p        (dsp_p),
    .dsp_carryout (dsp_carryout)
  );

  // slice: A1REG/B1REG, MREG, OPMODEREG, PREG, CARRYOUTREG (not reset)
  logic [17:0] a1 = '0, b1 = '0;
  logic [35:0] mreg = '0;
  logic [7:0]  opm_r = '0;
  logic [47:0] p_r = '0;
  logic        co_r = 1'b0;
  logic [47:0] xm, zm;

  always_comb begin
    xm = '0;
    zm = '0;
    if (opm_r[1:0] == 2'd1) xm = {12'b0, mreg};
    if (opm_r[1:0] == 2'd2) xm = p_r;
    if (opm_r[3:2] == 2'd2) zm = p_r;
  end

  always @(posedge clk) begin
    a1    <= dsp_a;
    b1    <= dsp_b;
    mreg  <= 36'(a1) * 36'(b1);
    opm_r <= dsp_opmode;
    {co_r, p_r} <= 49'(xm) + 49'(zm) + 49'(opm_r[5]);
  end

  assign dsp_p        = p_r;
  assign dsp_carryout = co_r;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  int n_cmp = 0;
  int n_err = 0;

  logic [17:0] op_a [64];
  logic [17:0] op_b [64];
  bit          vpat [128];
  logic [7:0]  opm_log [256];

  typedef struct packed {
    logic [7:0]       len;
    logic [7:0]       vp;
    logic [7:0][17:0] a;
    logic [7:0][17:0] b;
    logic [31:0]      exp_data;
    logic [7:0]       exp_lat;
  } vec_t;

  vec_t tbl [5];

  task automatic check(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // reference: whole-job sum of products, then truncation or clamp
  function automatic logic [33:0] model(input logic [63:0] s);
    logic [47:0] p;
    logic        c, st;
    logic [31:0] d;
    p  = s[47:0];
    c  = s[48];
`ifdef MAC_SAT_EN
    st = (|p[47:32]) | c;
`else
    st = 1'b0;
`endif
    d  = st ? 32'hFFFF_FFFF : p[31:0];
    return {st, c, d};
  endfunction

  task automatic run_job(input string nm, input int len, input int hold,
                         input logic [33:0] exp, input int exp_lat,
                         input bit chk_opm, input bit poke);
    int   idx = 0;
    int   cyc = 0;
    int   oerr = 0;
    int   k = 0;
    bit   acc, seen = 0, fst = 1;
    logic [7:0]  eo;
    logic [31:0] d0;
    io.m_ready = (hold == 0);
    start   = 1'b1;
    cfg_len = len[7:0];
    @(posedge clk); #1;
    start = 1'b0;
    while (cyc < 400) begin
      if (cyc < 256) opm_log[cyc] = dsp_opmode;
      if (io.m_valid) begin
        seen = 1;
        break;
      end
      if (idx < len) begin
        io.s_valid = vpat[cyc < 128 ? cyc : 127];
        io.s_a     = op_a[idx];
        io.s_b     = op_b[idx];
      end else begin
        io.s_valid = 1'b0;
      end
      acc = io.s_valid && io.s_ready;
      @(posedge clk); #1;
      cyc++;
      if (acc) idx++;
    end
    io.s_valid = 1'b0;
    check({nm, " m_valid_seen"}, 64'(seen), 64'd1);
    check({nm, " latency"}, 64'(cyc), 64'(exp_lat));
    check({nm, " m_data"}, 64'(io.m_data), 64'(exp[31:0]));
    check({nm, " m_carry"}, 64'(io.m_carry), 64'(exp[32]));
    check({nm, " m_sat"}, 64'(io.m_sat), 64'(exp[33]));
    if (chk_opm) begin
      for (int i = 0; k < len && i + 2 < 256; i++) begin
        if (vpat[i]) eo = fst ? OPM_FIRST : OPM_ACC;
        else         eo = OPM_HOLD;
        if (vpat[i]) begin
          fst = 0;
          k++;
        end
        if (opm_log[i+2] !== eo) oerr++;
      end
      check({nm, " opmode_seq_errs"}, 64'(oerr), 64'd0);
    end
    d0 = io.m_data;
    for (int h = 0; h < hold; h++) begin
      if (poke) begin
        start   = 1'b1;
        cfg_len = 8'd3;
      end
      @(posedge clk); #1;
      check({nm, " hold m_valid"}, 64'(io.m_valid), 64'd1);
      check({nm, " hold m_data"}, 64'(io.m_data), 64'(d0));
      if (poke) check({nm, " hold s_ready"}, 64'(io.s_ready), 64'd0);
    end
    io.m_ready = 1'b1;
    @(posedge clk); #1;
    check({nm, " released m_valid"}, 64'(io.m_valid), 64'd0);
    check({nm, " released busy"}, 64'(busy), 64'd0);
    start      = 1'b0;
    io.m_ready = 1'b0;
  endtask

  task automatic load_vec(input vec_t v);
    for (int i = 0; i < 8; i++) begin
      op_a[i] = v.a[i];
      op_b[i] = v.b[i];
      vpat[i] = v.vp[i];
    end
    for (int i = 8; i < 128; i++) vpat[i] = 1'b1;
  endtask

  initial begin
    logic [63:0] sum;
    logic [17:0] a_before;
    int          len, last, ones;
    rst = 1'b1;
    start = 1'b0;
    cfg_len = '0;
    io.s_valid = 1'b0;
    io.s_a = '0;
    io.s_b = '0;
    io.m_ready = 1'b0;

    tbl[0] = '0;
    tbl[0].len = 4; tbl[0].vp = 8'hFF;
    tbl[0].a[0] = 1; tbl[0].a[1] = 3; tbl[0].a[2] = 5; tbl[0].a[3] = 7;
    tbl[0].b[0] = 2; tbl[0].b[1] = 4; tbl[0].b[2] = 6; tbl[0].b[3] = 8;
    tbl[0].exp_data = 100; tbl[0].exp_lat = 8;
    tbl[1] = '0;
    tbl[1].len = 3; tbl[1].vp = 8'b1110_1001;
    tbl[1].a[0] = 10; tbl[1].a[1] = 2; tbl[1].a[2] = 4;
    tbl[1].b[0] = 10; tbl[1].b[1] = 3; tbl[1].b[2] = 5;
    tbl[1].exp_data = 126; tbl[1].exp_lat = 10;
    tbl[2] = '0;
    tbl[2].len = 2; tbl[2].vp = 8'hFF;
    tbl[2].a[0] = 1; tbl[2].a[1] = 1; tbl[2].b[0] = 1; tbl[2].b[1] = 1;
    tbl[2].exp_data = 2; tbl[2].exp_lat = 6;
    tbl[3] = '0;
    tbl[3].len = 1; tbl[3].vp = 8'hFF;
    tbl[3].a[0] = 7; tbl[3].b[0] = 9;
    tbl[3].exp_data = 63; tbl[3].exp_lat = 5;
    tbl[4] = '0;
    tbl[4].len = 0; tbl[4].vp = 8'hFF;
    tbl[4].exp_data = 0; tbl[4].exp_lat = 0;

    #12;
    check("rst busy", 64'(busy), 0);
    check("rst s_ready", 64'(io.s_ready), 0);
    check("rst m_valid", 64'(io.m_valid), 0);
    check("rst m_data", 64'(io.m_data), 0);
    check("rst m_carry", 64'(io.m_carry), 0);
    check("rst m_sat", 64'(io.m_sat), 0);
    check("rst dsp_a", 64'(dsp_a), 0);
    check("rst dsp_b", 64'(dsp_b), 0);
    check("rst dsp_opmode", 64'(dsp_opmode), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("idle dsp_opmode", 64'(dsp_opmode), 64'(OPM_HOLD));

    for (int v = 0; v < 5; v++) begin
      load_vec(tbl[v]);
      a_before = dsp_a;
      run_job($sformatf("vec%0d", v), int'(tbl[v].len), 0,
              {2'b00, tbl[v].exp_data}, int'(tbl[v].exp_lat),
              tbl[v].len != 0, 1'b0);
      if (tbl[v].len == 0)
        check("len0 dsp_a", 64'(dsp_a), 64'(a_before));
    end

    op_a[0] = 2; op_b[0] = 3; op_a[1] = 4; op_b[1] = 5;
    for (int i = 0; i < 128; i++) vpat[i] = 1'b1;
    run_job("hold10", 2, 10, 34'd26, 6, 1'b0, 1'b1);

    for (int i = 0; i < 5; i++) begin
      op_a[i] = 18'(i + 3);
      op_b[i] = 18'(i + 7);
    end
    start = 1'b1;
    cfg_len = 8'd5;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      io.s_valid = 1'b1;
      io.s_a = op_a[i];
      io.s_b = op_b[i];
      @(posedge clk); #1;
    end
    rst = 1'b1;
    #2;
    check("midrst busy", 64'(busy), 0);
    check("midrst s_ready", 64'(io.s_ready), 0);
    check("midrst m_valid", 64'(io.m_valid), 0);
    check("midrst m_data", 64'(io.m_data), 0);
    check("midrst dsp_a", 64'(dsp_a), 0);
    check("midrst dsp_b", 64'(dsp_b), 0);
    check("midrst dsp_opmode", 64'(dsp_opmode), 0);
    io.s_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    op_a[0] = 3; op_b[0] = 3;
    run_job("post_rst", 1, 0, 34'd9, 5, 1'b1, 1'b0);

    op_a[0] = 18'h20000; op_b[0] = 18'h20000;
    op_a[1] = 18'h20000; op_b[1] = 18'h20000;
    run_job("big", 2, 1, model(64'h8_0000_0000), 6, 1'b0, 1'b0);

    for (int j = 0; j < 25; j++) begin
      len = $urandom_range(1, 20);
      sum = '0;
      for (int i = 0; i < len; i++) begin
        op_a[i] = 18'($urandom());
        op_b[i] = 18'($urandom());
        sum += 64'(op_a[i]) * 64'(op_b[i]);
      end
      for (int i = 0; i < 128; i++)
        vpat[i] = (i >= 60) || ($urandom_range(0, 3) != 0);
      ones = 0;
      last = 0;
      for (int i = 0; ones < len; i++) begin
        if (vpat[i]) begin
          ones++;
          last = i;
        end
      end
      run_job($sformatf("rnd%0d", j), len, $urandom_range(0, 3),
              model(sum), last + 1 + 4, 1'b1, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dsp_mac_sequencer.md
Name: dsp_mac_sequencer

Overview:
Control stage that sits directly upstream of, and reads back from, the DSP48A1 slice model. It turns a valid/ready stream of operand pairs into per-cycle A/B/opmode drive for a multiply-accumulate of cfg_len products. It then captures the slice's P and CARRYOUT as one result word on a valid/ready output.
Slice configuration it targets: A0REG=0, A1REG=1, B0REG=0, B1REG=1, MREG=1, PREG=1, OPMODEREG=1, CARRYINREG=1, CARRYOUTREG=1, CARRYINSEL="OPMODE5", B_INPUT="DIRECT".

Parameters:
DATA_W, 18, operand width; must equal the slice A/B width.
ACC_W, 48, slice P width.
LEN_W, 8, width of the tap-count field; up to 255 products per job.
OUT_W, 32, result width presented on m_data; OUT_W <= ACC_W.
PIPE_LAT, 3, cycles from operands on dsp_a/dsp_b to the updated dsp_p being visible.
OPM_SKEW, 1, cycles that dsp_opmode lags the operands it applies to.

Ports:
clk  in  1  rising-edge clock, shared with the slice
rst  in  1  asynchronous, active-high reset
start  in  1  job request; sampled only in IDLE
cfg_len  in  LEN_W  number of products; sampled with start
busy  out  1  high in any state except IDLE
s_valid  in  1  operand pair valid
s_ready  out  1  operand pair accepted when s_valid and s_ready are both high
s_a  in  DATA_W  operand driven to the slice A port
s_b  in  DATA_W  operand driven to the slice B port
dsp_a  out  DATA_W  to slice A
dsp_b  out  DATA_W  to slice B
dsp_opmode  out  8  to slice opmode
dsp_p  in  ACC_W  from slice P
dsp_carryout  in  1  from slice CARRYOUT
m_valid  out  1  result valid
m_ready  in  1  result consumer ready
m_data  out  OUT_W  accumulated result
m_carry  out  1  slice CARRYOUT captured alongside m_data
m_sat  out  1  saturation flag; tied 0 unless the optional feature is enabled

Behaviour:
- Reset values: IDLE state; busy=0, s_ready=0, m_valid=0, m_data=0, m_carry=0, m_sat=0, dsp_a=0, dsp_b=0, dsp_opmode=8'h00. All counters are cleared.
- Opmode constants:
  - OPM_FIRST=8'h01: X=M, Z=0, add, carry-in 0.
  - OPM_ACC=8'h09: X=M, Z=P.
  - OPM_HOLD=8'h08: X=0, Z=P, so P is held.
- dsp_a, dsp_b, dsp_opmode are registered outputs.
- IDLE:
  - s_ready=0; dsp_opmode=OPM_HOLD after the first post-reset cycle.
  - start=1 with cfg_len!=0: load remaining=cfg_len, set first=1, go to RUN.
  - start=1 with cfg_len=0: go directly to DONE with m_data=0, m_carry=0; no beats are issued.
- RUN:
  - s_ready=1.
  - Each accepted beat registers s_a/s_b onto dsp_a/dsp_b and decrements remaining.
  - Accepted beat: its opmode tag is OPM_FIRST if first, else OPM_ACC; first is then cleared.
  - Bubble (s_valid=0): dsp_a/dsp_b hold, tag is OPM_HOLD.
  - Tags pass through an OPM_SKEW-deep delay, so dsp_opmode for beat k is driven exactly OPM_SKEW cycles after dsp_a/dsp_b carry beat k.
  - On acceptance of the final beat (remaining=1): s_ready drops the next cycle and the FSM goes to DRAIN.
- DRAIN:
  - s_ready=0; the tag input is OPM_HOLD.
  - Wait counter runs PIPE_LAT cycles, counted from the cycle the last operands were on dsp_a/dsp_b.
  - In cycle t+PIPE_LAT: capture dsp_p into m_data (truncated to OUT_W bits) and dsp_carryout into m_carry, assert m_valid, go to DONE.
- DONE:
  - m_valid=1; m_data, m_carry, m_sat are held stable until m_ready.
  - On m_valid & m_ready: m_valid=0 next cycle, go to IDLE. A start in that same cycle is ignored.
- Throughput: 1 product/cycle when s_valid stays high. Job latency = cfg_len + PIPE_LAT + 1 cycles from the start cycle to m_valid.
- start outside IDLE is ignored; cfg_len changes outside IDLE have no effect.
- Arithmetic is unsigned, matching the slice multiplier. Accumulator wrap is the slice's own behaviour and is reported via m_carry.
- rst mid-job: all state returns to reset values immediately and the job is discarded. The P register in the slice is not cleared; the next job's OPM_FIRST overwrites it.

Optional Feature:
Macro MAC_SAT_EN.
- Defined: if any bit of dsp_p[ACC_W-1:OUT_W] is set, or dsp_carryout=1, at capture, then m_data = all ones and m_sat=1. Otherwise m_data = dsp_p[OUT_W-1:0] and m_sat=0.
- Undefined: m_data = dsp_p[OUT_W-1:0] truncated; m_sat is constant 0.

Decomposition:
- Shared package dsp_pkg: OPM_FIRST, OPM_HOLD, OPM_ACC constants; FSM state enum (IDLE, RUN, DRAIN, DONE); DATA_W/ACC_W defaults.
- One sub-module: dsp_opm_delay, a parameterised width x depth register delay for the opmode tag, with async reset to 8'h00.

Test Plan:
The bench instantiates the slice with the configuration listed in Overview.
- cfg_len=4, pairs (1,2),(3,4),(5,6),(7,8) back-to-back, m_ready=1 -> m_data=100, m_carry=0, m_valid exactly 8 cycles after start.
- cfg_len=3, s_valid toggling 1,0,0,1,0,1 with (10,10),(2,3),(4,5) -> m_data=126; bubble cycles show dsp_opmode=8'h08.
- Two jobs: cfg_len=2 (1,1),(1,1), then cfg_len=1 (7,9) -> results 2 then 63; no carry-over from the first job.
- cfg_len=0 -> m_valid the cycle after DONE entry, m_data=0; dsp_a never changes.
- m_ready held 0 for 10 cycles in DONE -> m_data stable, s_ready=0, start ignored; m_ready=1 -> IDLE next cycle.
- rst pulsed mid-RUN of a cfg_len=5 job -> all outputs at reset values asynchronously; a fresh cfg_len=1 (3,3) job gives 9. With MAC_SAT_EN and OUT_W=32, a (2^17,2^17) x2 job gives 0xFFFFFFFF with m_sat=1.
